// File: rtl/counter_seq_pkg.sv
// Shared types and constants for the counter sequencer.
// Imported by the controller and its step timer.
package counter_seq_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        OP_CLR  = 2'd0,
        OP_UP   = 2'd1,
        OP_DOWN = 2'd2,
        OP_GOTO = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/seq_step_timer.sv
// Loadable down-counter for the number of remaining counter steps.
// last flags the final step (count == 1).
module seq_step_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             last
);

    logic [WIDTH-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == WIDTH'(1));

endmodule

// File: rtl/counter_seq_ctrl.sv
// Command-driven sequencer for the up/down counter: CLR, UP N, DOWN N, GOTO target,
// with early abort and a one-cycle done pulse carrying the final counter value.
module counter_seq_ctrl #(
    parameter int WIDTH = counter_seq_pkg::WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    input  logic             abort,
    input  logic [WIDTH-1:0] cnt_value,
    output logic             cnt_enable,
    output logic             cnt_up_down,
    output logic             cnt_reset,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] done_value
);

    import counter_seq_pkg::*;

    op_t              op;
    state_t           state;
    state_t           state_next;
    logic             accept;
    logic [WIDTH-1:0] step_n;
    logic             step_up;
    logic             step_last;
    logic             enable_q;
    logic [WIDTH-1:0] value_after_edge;

    assign op        = op_t'(cmd_op);
    assign cmd_ready = (state == S_IDLE) && !reset;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state != S_IDLE);
    assign cnt_reset = reset || (state == S_CLEAR);

    // Abort must stop the counter in the very cycle it is seen, hence the gate after the register.
    assign cnt_enable = enable_q && !abort;

    // Step count and direction; GOTO follows the plain numeric comparison, never a wrap path.
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        step_n  = '0;
        step_up = 1'b1;
        unique case (op)
            OP_UP: begin
                step_n  = cmd_arg;
                step_up = 1'b1;
            end
            OP_DOWN: begin
                step_n  = cmd_arg;
                step_up = 1'b0;
            end
            OP_GOTO: begin
                if (cmd_arg > cnt_value) begin
                    step_n  = cmd_arg - cnt_value;
                    step_up = 1'b1;
                end else begin
                    step_n  = cnt_value - cmd_arg;
                    step_up = 1'b0;
                end
            end
            OP_CLR: begin
                step_n  = '0;
                step_up = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    if (op == OP_CLR) begin
                        state_next = S_CLEAR;
                    end else if (step_n == '0) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_RUN;
                    end
                end
            end
            S_CLEAR: state_next = S_DONE;
            S_RUN: begin
                if (abort || step_last) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
        endcase
    end

    // Value the counter will hold after this edge, so a registered done_value already
    // equals cnt_value during the done cycle.
    always_comb begin
        if (cnt_reset) begin
            value_after_edge = '0;
        end else if (cnt_enable) begin
            value_after_edge = cnt_up_down ? (cnt_value + 1'b1) : (cnt_value - 1'b1);
        end else begin
            value_after_edge = cnt_value;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            enable_q    <= 1'b0;
            cnt_up_down <= 1'b0;
            done        <= 1'b0;
            done_value  <= '0;
        end else begin
            state    <= state_next;
            enable_q <= (state_next == S_RUN);
            done     <= (state_next == S_DONE);
            if (accept && (op != OP_CLR)) begin
                cnt_up_down <= step_up;
            end
            if (state_next == S_DONE) begin
                done_value <= value_after_edge;
            end
        end
    end

    seq_step_timer #(
        .WIDTH (WIDTH)
    ) u_step_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .load_value (step_n),
        .dec        (state == S_RUN),
        .last       (step_last)
    );

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl driving a behavioural 8-bit up/down counter.
module tb_counter_seq_ctrl;

    import counter_seq_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_arg;
    logic         abort;
    logic [W-1:0] cnt_value;
    logic         cnt_enable;
    logic         cnt_up_down;
    logic         cnt_reset;
    logic         busy;
    logic         done;
    logic [W-1:0] done_value;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    counter_seq_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_arg     (cmd_arg),
        .abort       (abort),
        .cnt_value   (cnt_value),
        .cnt_enable  (cnt_enable),
        .cnt_up_down (cnt_up_down),
        .cnt_reset   (cnt_reset),
        .busy        (busy),
        .done        (done),
        .done_value  (done_value)
    );

    // Stand-in for the existing counter block: synchronous reset, wraps modulo 256.
    always_ff @(posedge clk) begin
        if (cnt_reset) begin
            cnt_value <= '0;
        end else if (cnt_enable) begin
            cnt_value <= cnt_up_down ? cnt_value + 1'b1 : cnt_value - 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one command at cycle T and watches until done; lat is the done cycle offset from T.
    task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] arg, input int abort_at,
                           output int rdy, output int lat, output int en_cnt, output int clr_cnt,
                           output logic [W-1:0] val, output int idle_ok);
        lat = -1; en_cnt = 0; clr_cnt = 0; val = '0; idle_ok = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        #1;
        rdy = int'(cmd_ready);
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            abort     = (abort_at != 0) && (k == abort_at);
            #1;
            if (cnt_enable) en_cnt++;
            if (cnt_reset)  clr_cnt++;
            if (done) begin
                lat = k;
                val = done_value;
                break;
            end
        end
        abort = 1'b0;
        @(negedge clk);
        #1;
        idle_ok = int'(!busy && cmd_ready && !done);
    endtask

    initial begin
        int rdy, lat, en_cnt, clr_cnt, idle_ok, acc, dn;
        logic [W-1:0] val;

        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_arg = '0; abort = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_cnt_reset", cnt_reset, 1);
        check("rst_ready_low", cmd_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_enable", cnt_enable, 0);
        check("rst_done", done, 0);
        check("rst_done_value", done_value, 0);
        check("rst_up_down", cnt_up_down, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_cnt_value", cnt_value, 0);

        // Bring counter to 0x37.
        run_cmd(OP_UP, 8'h37, 0, rdy, lat, en_cnt, clr_cnt, val, idle_ok);
        check("up37_lat", lat, 56);
        check("up37_en", en_cnt, 55);
        check("up37_val", val, 8'h37);

        // Clear from nonzero.
        run_cmd(OP_CLR, 8'hAA, 0, rdy, lat, en_cnt, clr_cnt, val, idle_ok);
        check("clr_ready", rdy, 1);
        check("clr_lat", lat, 2);
        check("clr_reset_cycles", clr_cnt, 1);
        check("clr_en", en_cnt, 0);
        check("clr_val", val, 8'h00);
        check("clr_idle_t3", idle_ok, 1);

        // Count up 5.
        run_cmd(OP_UP, 8'd5, 0, rdy, lat, en_cnt, clr_cnt, val, idle_ok);
        check("up5_lat", lat, 6);
        check("up5_en", en_cnt, 5);
        check("up5_val", val, 8'h05);
        check("up5_idle_t7", idle_ok, 1);

        // Down 7 wraps 0x05 -> 0xFE.
        run_cmd(OP_DOWN, 8'd7, 0, rdy, lat, en_cnt, clr_cnt, val, idle_ok);
        check("down7_lat", lat, 8);
        check("down7_val", val, 8'hFE);

        run_cmd(OP_UP, 8'd3, 0, rdy, lat, en_cnt, clr_cnt, val, idle_ok);
        check("wrap_up3_lat", lat, 4);
        check("wrap_up3_val", val, 8'h01);

        run_cmd(OP_DOWN, 8'd2, 0, rdy, lat, en_cnt, clr_cnt, val, idle_ok);
        check("wrap_dn2_lat", lat, 3);
        check("wrap_dn2_val", val, 8'hFF);

        // GOTO 0x10 from 0xFF goes down 0xEF steps, no wrap shortcut.
        run_cmd(OP_GOTO, 8'h10, 0, rdy, lat, en_cnt, clr_cnt, val, idle_ok);
        check("goto10_lat", lat, 240);
        check("goto10_en", en_cnt, 239);
        check("goto10_val", val, 8'h10);

        run_cmd(OP_GOTO, 8'h0C, 0, rdy, lat, en_cnt, clr_cnt, val, idle_ok);
        check("goto0c_lat", lat, 5);
        check("goto0c_en", en_cnt, 4);
        check("goto0c_val", val, 8'h0C);

        run_cmd(OP_GOTO, 8'h0C, 0, rdy, lat, en_cnt, clr_cnt, val, idle_ok);
        check("goto_eq_lat", lat, 1);
        check("goto_eq_en", en_cnt, 0);
        check("goto_eq_val", val, 8'h0C);

        run_cmd(OP_UP, 8'd0, 0, rdy, lat, en_cnt, clr_cnt, val, idle_ok);
        check("up0_lat", lat, 1);
        check("up0_en", en_cnt, 0);

        // Abort during UP 10 at T+4.
        run_cmd(OP_CLR, 8'd0, 0, rdy, lat, en_cnt, clr_cnt, val, idle_ok);
        check("clr2_val", val, 8'h00);
        run_cmd(OP_UP, 8'd10, 4, rdy, lat, en_cnt, clr_cnt, val, idle_ok);
        check("abort_lat", lat, 5);
        check("abort_en", en_cnt, 3);
        check("abort_val", val, 8'h03);
        check("abort_idle", idle_ok, 1);

        // cmd_valid held high across busy periods: one acceptance per command.
        acc = 0; dn = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            cmd_valid = 1'b1; cmd_op = OP_UP; cmd_arg = 8'd2;
            #1;
            if (cmd_valid && cmd_ready) acc++;
            if (done) dn++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        check("hold_accepts", acc, 3);
        check("hold_dones", dn, 3);
        check("hold_cnt_value", cnt_value, 8'h09);

        // Reset in the middle of UP 20.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_UP; cmd_arg = 8'd20;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("midrun_busy", busy, 1);
        check("midrun_up_down", cnt_up_down, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_cnt_reset", cnt_reset, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_enable", cnt_enable, 0);
        check("midrst_done", done, 0);
        check("midrst_up_down", cnt_up_down, 0);
        check("midrst_done_value", done_value, 0);
        check("midrst_cnt_value", cnt_value, 0);
        dn = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            #1;
            if (done || busy) dn++;
        end
        check("midrst_no_done", dn, 0);
        check("midrst_cnt_hold", cnt_value, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
Command-driven sequencer for the 8-bit up/down counter datapath. It accepts one command at a time over a valid/ready handshake: clear, count up N, count down N, or go to a target value. It drives the counter's enable, up_down and reset inputs cycle by cycle and observes the counter's value. It reports completion with a one-cycle done pulse carrying the final counter value. It sits between a test or control master and a single counter instance.

Parameters:
WIDTH, 8, width of counter value, step argument and target.

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  synchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command
cmd_op  in  2  0=CLR, 1=UP, 2=DOWN, 3=GOTO
cmd_arg  in  WIDTH  step count (UP/DOWN), target value (GOTO), ignored for CLR
abort  in  1  terminate a running UP/DOWN/GOTO early
cnt_value  in  WIDTH  counter output
cnt_enable  out  1  counter enable
cnt_up_down  out  1  1=up, 0=down
cnt_reset  out  1  counter synchronous reset
busy  out  1  command in progress (state != IDLE)
done  out  1  one-cycle completion pulse
done_value  out  WIDTH  cnt_value sampled in the done cycle; held until next done

Behaviour:
- States: IDLE, CLEAR, RUN, DONE. Reset puts the FSM in IDLE.
- Reset values: cnt_enable=0, cnt_up_down=0, busy=0, done=0, done_value=0, step counter=0.
- cnt_reset is driven as (reset OR state==CLEAR), so the counter is cleared together with the controller.
- cmd_ready=1 only when state==IDLE and reset=0. Acceptance is cmd_valid&&cmd_ready at cycle T. cmd_op and cmd_arg are sampled at T.
- CLR: state CLEAR at T+1 (cnt_reset=1), then DONE at T+2 with done_value=0, then IDLE at T+3.
- UP/DOWN with arg N>0:
  - RUN at T+1..T+N. cnt_enable=1 and cnt_up_down is fixed for the whole command (1 for UP, 0 for DOWN).
  - The step counter loads N at T and decrements each RUN cycle. RUN exits when it reaches 1.
  - DONE at T+N+1, where cnt_value already reflects all N steps. IDLE at T+N+2.
- UP/DOWN with N=0: DONE at T+1, cnt_enable never asserted.
- GOTO:
  - At T, compare cmd_arg with cnt_value (the counter is idle, so the value is stable).
  - Equal: behaves as N=0.
  - Greater: UP with N=arg-value. Less: DOWN with N=value-arg.
  - No shortest-path wrap: the direction follows only the numeric comparison.
- Wrap-around: the counter wraps modulo 2^WIDTH (255+1=0, 0-1=255). The controller counts steps only and never checks for overflow.
- abort is honoured only in RUN. If abort=1 in a RUN cycle, cnt_enable=0 that cycle, the next state is DONE, and done_value is the partial value. abort is ignored in all other states.
- The maximum step count per command is 2^WIDTH-1.
- cmd_valid while busy: not accepted; the master must hold it.
- Reset mid-command: FSM returns to IDLE immediately, outputs take reset values, the counter is cleared via cnt_reset, and no done pulse is produced.
- cnt_enable, cnt_up_down, done and done_value are registered outputs (state-decoded).

Decomposition:
- Package counter_seq_pkg holds:
  - the op typedef enum (OP_CLR, OP_UP, OP_DOWN, OP_GOTO);
  - the state typedef enum (S_IDLE, S_CLEAR, S_RUN, S_DONE);
  - the WIDTH default constant.
- One natural sub-module, seq_step_timer: a loadable down-counter that asserts last when its count equals 1.
- The top level holds the FSM, the GOTO compare/subtract and the output registers.
- The verification top instantiates counter_seq_ctrl plus the existing counter block.

Test Plan:
- Clear from a nonzero value: counter at 0x37, CLR -> cnt_reset high one cycle; done at T+2 with done_value=0x00; cmd_ready back at T+3.
- Count up: from 0x00, UP 5 -> cnt_enable high exactly 5 cycles; done at T+6 with done_value=0x05; busy low at T+7.
- Wrap both ways: from 0xFE, UP 3 -> done_value=0x01; then DOWN 2 -> done_value=0xFF.
- GOTO both directions: from 0x10, GOTO 0x0C -> 4 down steps, done_value=0x0C; GOTO 0x0C again -> done at T+1, no enable pulses.
- Abort: from 0x00, UP 10, abort asserted at T+4 -> only 3 enable cycles; done at T+5 with done_value=0x03.
- Reset mid-RUN and busy hold: reset during UP 20 -> outputs return to reset values, no done pulse, counter cleared. cmd_valid held high while busy -> exactly one acceptance per command.
